jtag_tap_controller: RTL and testbench

// - IEEE 1149.1-style TAP controller that sequences the JTAG core-logic datapath.
// - Decodes TMS into the 16-state TAP FSM and drives SHIFTDR to the core.
// - Owns a 4-bit IR and the IDCODE, BYPASS and CORE_DATA data registers.
// - Captures CORE_LOGIC_DATA on TDI/TDO and returns updated words to the core.

---
 rtl/jtag_tap_controller_if.sv | 11 +
 rtl/jtag_tap_controller.sv | 74 +++++++
 tb/tb_jtag_tap_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/jtag_tap_controller_if.sv
// jtag_tap_controller_if: TAP pins and core-side datapath signals of the JTAG controller
interface jtag_tap_controller_if #(parameter int IR_WIDTH = 4, parameter int DR_WIDTH = 8);
  logic TMS, TDI, TDO, TDO_EN, SHIFTDR, UPDATE_STB;
  logic [DR_WIDTH-1:0] CORE_LOGIC_DATA, DR_UPDATE;
  logic [IR_WIDTH-1:0] IR_OUT;
  logic [3:0] TAP_STATE;
  modport master (output TMS, TDI, CORE_LOGIC_DATA,
                  input TDO, TDO_EN, SHIFTDR, DR_UPDATE, UPDATE_STB, IR_OUT, TAP_STATE);
  modport slave (input TMS, TDI, CORE_LOGIC_DATA,
                 output TDO, TDO_EN, SHIFTDR, DR_UPDATE, UPDATE_STB, IR_OUT, TAP_STATE);
endinterface

// File: rtl/jtag_tap_controller.sv
// jtag_tap_controller: 1149.1 TAP FSM with IR, IDCODE, BYPASS and core data registers
module jtag_tap_controller #(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 8,
  parameter logic [31:0] IDCODE_VALUE = 32'h0DDC_0DE1,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE = 4'h1,
  parameter logic [IR_WIDTH-1:0] OP_CORE_DATA = 4'h2
) (
  input logic TCK,
  input logic TRST,
  jtag_tap_controller_if.slave tap
);
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR
  } state_t;
  state_t state, next;
  logic [IR_WIDTH-1:0] ir, ir_sr;
  logic [31:0] id_sr;
  logic [DR_WIDTH-1:0] dr_sr, dr_update;
  logic byp, stb, shiftdr, sel_id, sel_core;
  always_ff @(posedge TCK)
    state <= !TRST ? TLR : next;
  always_comb begin
    next = state;
    case (state)
      TLR:          next = tap.TMS ? TLR   : RTI;
      RTI:          next = tap.TMS ? SELDR : RTI;
      SELDR:        next = tap.TMS ? SELIR : CAPDR;
      SELIR:        next = tap.TMS ? TLR   : CAPIR;
      CAPDR, SHDR:  next = tap.TMS ? EX1DR : SHDR;
      EX1DR:        next = tap.TMS ? UPDR  : PSDR;
      PSDR:         next = tap.TMS ? EX2DR : PSDR;
      EX2DR:        next = tap.TMS ? UPDR  : SHDR;
      CAPIR, SHIR:  next = tap.TMS ? EX1IR : SHIR;
      EX1IR:        next = tap.TMS ? UPIR  : PSIR;
      PSIR:         next = tap.TMS ? EX2IR : PSIR;
      EX2IR:        next = tap.TMS ? UPIR  : SHIR;
      UPDR, UPIR:   next = tap.TMS ? SELDR : RTI;
    endcase
  end
  assign sel_id = ir == OP_IDCODE;
  assign sel_core = ir == OP_CORE_DATA;
  // Capture on the edge taken in CAPTURE, shift on edges taken in SHIFT, update on the UPDATE edge
  always_ff @(posedge TCK)
    if (!TRST) begin
      ir <= OP_IDCODE;
      ir_sr <= '0;
      id_sr <= '0;
      dr_sr <= '0;
      byp <= 1'b0;
      dr_update <= '0;
      stb <= 1'b0;
      shiftdr <= 1'b0;
    end else begin
      ir <= next == TLR ? OP_IDCODE : state == UPIR ? ir_sr : ir;
      ir_sr <= state == CAPIR ? IR_WIDTH'(1) : state == SHIR ? {tap.TDI, ir_sr[IR_WIDTH-1:1]} : ir_sr;
      id_sr <= !sel_id ? id_sr : state == CAPDR ? IDCODE_VALUE : state == SHDR ? {tap.TDI, id_sr[31:1]} : id_sr;
      dr_sr <= !sel_core ? dr_sr : state == CAPDR ? tap.CORE_LOGIC_DATA : state == SHDR ? {tap.TDI, dr_sr[DR_WIDTH-1:1]} : dr_sr;
      byp <= sel_id || sel_core ? byp : state == CAPDR ? 1'b0 : state == SHDR ? tap.TDI : byp;
      dr_update <= state == UPDR && sel_core ? dr_sr : dr_update;
      stb <= state == UPDR && sel_core;
      shiftdr <= next == SHDR;
    end
  assign tap.TDO_EN = state == SHDR || state == SHIR;
  assign tap.TDO = state == SHIR ? ir_sr[0] :
                   state != SHDR ? 1'b0 :
                   sel_id ? id_sr[0] : sel_core ? dr_sr[0] : byp;
  assign tap.SHIFTDR = shiftdr;
  assign tap.DR_UPDATE = dr_update;
  assign tap.UPDATE_STB = stb;
  assign tap.IR_OUT = ir;
  assign tap.TAP_STATE = state;
endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb_jtag_tap_controller: table-driven FSM walk plus directed IDCODE, core data, bypass and reset sequences
module tb_jtag_tap_controller;
  logic TCK = 1'b0;
  logic TRST = 1'b0;
  int checks = 0;
  int errors = 0;
  jtag_tap_controller_if #(.IR_WIDTH(4), .DR_WIDTH(8)) tap ();
  jtag_tap_controller dut (.TCK(TCK), .TRST(TRST), .tap(tap));
  always #5 TCK = ~TCK;
  typedef struct {
    logic tms;
    logic [3:0] exp_st;
    logic [3:0] exp_ir;
  } vec_t;
  vec_t vecs[26];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic step(input logic tms, input logic tdi);
    tap.TMS = tms;
    tap.TDI = tdi;
    @(posedge TCK);
    #1;
  endtask
  task automatic load_ir(input logic [3:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ir_capture_tdo", tap.TDO, i == 0);
      step(i == 3, v[i]);
    end
    step(1, 0); step(0, 0);
    chk("ir_load", tap.IR_OUT, v);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] word;
    logic [7:0] shin;
    logic [7:0] core;
    logic [2:0] bp;
    vecs = '{
      '{1'b1, 4'h0, 4'h1}, '{1'b0, 4'h1, 4'h1}, '{1'b0, 4'h1, 4'h1}, '{1'b1, 4'h2, 4'h1},
      '{1'b0, 4'h3, 4'h1}, '{1'b0, 4'h4, 4'h1}, '{1'b1, 4'h5, 4'h1}, '{1'b0, 4'h6, 4'h1},
      '{1'b0, 4'h6, 4'h1}, '{1'b1, 4'h7, 4'h1}, '{1'b0, 4'h4, 4'h1}, '{1'b1, 4'h5, 4'h1},
      '{1'b1, 4'h8, 4'h1}, '{1'b1, 4'h2, 4'h1}, '{1'b1, 4'h9, 4'h1}, '{1'b0, 4'hA, 4'h1},
      '{1'b1, 4'hC, 4'h1}, '{1'b0, 4'hD, 4'h1}, '{1'b1, 4'hE, 4'h1}, '{1'b0, 4'hB, 4'h1},
      '{1'b1, 4'hC, 4'h1}, '{1'b1, 4'hF, 4'h1}, '{1'b0, 4'h1, 4'h0}, '{1'b1, 4'h2, 4'h0},
      '{1'b1, 4'h9, 4'h0}, '{1'b1, 4'h0, 4'h1}
    };
    tap.CORE_LOGIC_DATA = 8'h00;
    TRST = 1'b0;
    for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 0);
    chk("rst_state", tap.TAP_STATE, 4'h0);
    chk("rst_ir", tap.IR_OUT, 4'h1);
    chk("rst_tdo_en", tap.TDO_EN, 0);
    chk("rst_dr_update", tap.DR_UPDATE, 0);
    chk("rst_stb", tap.UPDATE_STB, 0);
    chk("rst_shiftdr", tap.SHIFTDR, 0);
    TRST = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step(vecs[i].tms, 0);
      chk($sformatf("walk%0d_state", i), tap.TAP_STATE, vecs[i].exp_st);
      chk($sformatf("walk%0d_ir", i), tap.IR_OUT, vecs[i].exp_ir);
      chk($sformatf("walk%0d_tdo_en", i), tap.TDO_EN, vecs[i].exp_st == 4'h4 || vecs[i].exp_st == 4'hB);
      chk($sformatf("walk%0d_shiftdr", i), tap.SHIFTDR, vecs[i].exp_st == 4'h4);
      chk($sformatf("walk%0d_stb", i), tap.UPDATE_STB, 0);
    end
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("id_in_shdr", tap.TAP_STATE, 4'h4);
    for (int i = 0; i < 32; i++) begin
      word[i] = tap.TDO;
      step(0, 0);
    end
    chk("idcode", word, 32'h0DDC_0DE1);
    step(1, 0); step(1, 0); step(0, 0);
    chk("updr_noncore_stb", tap.UPDATE_STB, 0);
    chk("updr_noncore_dr", tap.DR_UPDATE, 0);
    load_ir(4'h2);
    tap.CORE_LOGIC_DATA = 8'hDD;
    core = 8'hDD;
    shin = 8'hA5;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("core_tdo%0d", i), tap.TDO, core[i]);
      chk($sformatf("core_shiftdr%0d", i), tap.SHIFTDR, 1);
      step(i == 7, shin[i]);
    end
    chk("ex1dr_shiftdr", tap.SHIFTDR, 0);
    chk("ex1dr_tdo", tap.TDO, 0);
    step(1, 0);
    chk("updr_stb_pre", tap.UPDATE_STB, 0);
    step(0, 0);
    chk("upd_stb", tap.UPDATE_STB, 1);
    chk("upd_value", tap.DR_UPDATE, 8'hA5);
    step(0, 0);
    chk("upd_stb_once", tap.UPDATE_STB, 0);
    chk("upd_value_hold", tap.DR_UPDATE, 8'hA5);
    step(1, 0); step(0, 0); step(0, 0);
    chk("park_shiftdr", tap.SHIFTDR, 1);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tms5_state", tap.TAP_STATE, 4'h0);
    chk("tms5_ir", tap.IR_OUT, 4'h1);
    step(0, 0);
    load_ir(4'hF);
    step(1, 0); step(0, 0); step(0, 0);
    bp = 3'b101;
    chk("byp_tdo0", tap.TDO, 0);
    step(0, bp[0]);
    chk("byp_tdo1", tap.TDO, 1);
    step(0, bp[1]);
    chk("byp_tdo2", tap.TDO, 0);
    step(0, bp[2]);
    chk("byp_tdo3", tap.TDO, 1);
    TRST = 1'b0;
    step(0, 0);
    chk("midrst_state", tap.TAP_STATE, 4'h0);
    chk("midrst_ir", tap.IR_OUT, 4'h1);
    chk("midrst_stb", tap.UPDATE_STB, 0);
    chk("midrst_dr", tap.DR_UPDATE, 0);
    chk("midrst_tdo_en", tap.TDO_EN, 0);
    TRST = 1'b1;
    step(1, 0);
    chk("post_rst_stb", tap.UPDATE_STB, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
